// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Holds REG_NUM x XLEN values, a busy bit and a ROB tag per register.
// ROB commits write values and release matching tags, decoder renames set
// tags, and two operand queries are answered combinationally.
// Optional feature macro: RF_COMMIT_BYPASS_EN -- when defined, a query that
// matches a same-cycle releasing commit returns the committed value directly.
module reg_file #(
  parameter int ROB_SIZE_BIT = 5,
  parameter int REG_NUM      = 32,
  parameter int XLEN         = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [4:0]              update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [XLEN-1:0]         update_val,
  input  logic                    is_update_dep,
  input  logic [4:0]              update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [4:0]              qry1_reg_id,
  output logic                    qry1_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  output logic [XLEN-1:0]         qry1_value,
  input  logic [4:0]              qry2_reg_id,
  output logic                    qry2_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep,
  output logic [XLEN-1:0]         qry2_value
);

  logic [XLEN-1:0]         values [REG_NUM];
  logic [ROB_SIZE_BIT-1:0] tags   [REG_NUM];
  logic [REG_NUM-1:0]      busy;

  logic commit_ok;
  logic rename_ok;

  // Qualified update strobes; x0 is hardwired and never written or renamed.
  assign commit_ok = rdy_in && is_update_val && (update_val_id != 5'd0);
  assign rename_ok = rdy_in && is_update_dep && (update_dep_id != 5'd0) && !rob_clear;

  // State update: commit first, then flush or rename so the later assignment wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: the storage array is reset in full because readers must see
      // value 0 / not busy / tag 0 immediately after reset; this keeps it out
      // of plain RAM macros, which is accepted for a 32-entry file.
      for (int i = 0; i < REG_NUM; i++) begin
        values[i] <= '0;
        tags[i]   <= '0;
      end
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments here mean a rename later in this block
      // overrides a busy-clear from the commit above for the same register.
      if (commit_ok) begin
        values[update_val_id] <= update_val;
        if (busy[update_val_id] && (tags[update_val_id] == update_val_dep))
          busy[update_val_id] <= 1'b0;
      end
      if (rdy_in && rob_clear)
        busy <= '0;
      else if (rename_ok) begin
        busy[update_dep_id] <= 1'b1;
        tags[update_dep_id] <= update_dep;
      end
    end
  end

`ifdef RF_COMMIT_BYPASS_EN
  logic bypass1;
  logic bypass2;

  // A query is bypassed when this cycle's commit releases its producer tag.
  assign bypass1 = commit_ok && (update_val_id == qry1_reg_id) &&
                   busy[qry1_reg_id] && (tags[qry1_reg_id] == update_val_dep);
  assign bypass2 = commit_ok && (update_val_id == qry2_reg_id) &&
                   busy[qry2_reg_id] && (tags[qry2_reg_id] == update_val_dep);
`else
  logic bypass1;
  logic bypass2;

  // Without the bypass a same-cycle commit is seen only from the next cycle.
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // Operand 1 lookup; x0 always reads as a ready zero.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    qry1_has_dep = 1'b0;
    qry1_dep     = '0;
    qry1_value   = '0;
    if (qry1_reg_id != 5'd0) begin
      qry1_has_dep = busy[qry1_reg_id];
      qry1_dep     = tags[qry1_reg_id];
      qry1_value   = values[qry1_reg_id];
      if (bypass1) begin
        qry1_has_dep = 1'b0;
        qry1_value   = update_val;
      end
    end
  end

  // Operand 2 lookup; identical to operand 1.
  always_comb begin
    qry2_has_dep = 1'b0;
    qry2_dep     = '0;
    qry2_value   = '0;
    if (qry2_reg_id != 5'd0) begin
      qry2_has_dep = busy[qry2_reg_id];
      qry2_dep     = tags[qry2_reg_id];
      qry2_value   = values[qry2_reg_id];
      if (bypass2) begin
        qry2_has_dep = 1'b0;
        qry2_value   = update_val;
      end
    end
  end

endmodule
